// File: rtl/l2_cache_control.sv
// l2_cache_control: hit/miss sequencing, writeback/fill handshakes and saturating perf counters for a 2-way L2.
module l2_cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 d_out0,
    input  logic                 d_out1,
    input  logic                 lru_out,
    output logic                 load_lru,
    output logic                 lru_in,
    output logic                 load_TD0,
    output logic                 load_d0,
    output logic                 load_v0,
    output logic                 d_in0,
    output logic                 v_in0,
    output logic                 load_TD1,
    output logic                 load_d1,
    output logic                 load_v1,
    output logic                 d_in1,
    output logic                 v_in1,
    output logic                 l2wdata_sel,
    output logic [1:0]           l2addr_sel,
    output logic                 l2_read,
    output logic                 l2_write,
    input  logic                 l2_resp,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
    state_t state_q, state_d;
    logic victim_q, victim_d, retry_q, retry_d, wb_done, req, wr_hit0, wr_hit1;
    logic [CNT_WIDTH-1:0] hit_q, miss_q, wb_q;
    always_comb begin
        state_d = state_q;
        victim_d = victim_q;
        retry_d = retry_q;
        wb_done = 1'b0;
        mem_resp = 1'b0;
        load_lru = 1'b0;
        lru_in = 1'b0;
        load_TD0 = 1'b0;
        load_d0 = 1'b0;
        load_v0 = 1'b0;
        d_in0 = 1'b0;
        v_in0 = 1'b0;
        load_TD1 = 1'b0;
        load_d1 = 1'b0;
        load_v1 = 1'b0;
        d_in1 = 1'b0;
        v_in1 = 1'b0;
        l2wdata_sel = 1'b0;
        l2addr_sel = 2'd0;
        l2_read = 1'b0;
        l2_write = 1'b0;
        req = mem_read | mem_write;
        wr_hit0 = mem_write & hit0;
        wr_hit1 = mem_write & !hit0 & hit1;
        // Outputs are forced low while reset is held so no strobe or resp leaks out mid-transaction.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (req && (hit0 || hit1)) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_in = hit0;
                        l2wdata_sel = !hit0;
                        load_TD0 = wr_hit0;
                        load_d0 = wr_hit0;
                        d_in0 = wr_hit0;
                        load_TD1 = wr_hit1;
                        load_d1 = wr_hit1;
                        d_in1 = wr_hit1;
                        retry_d = 1'b0;
                    end else if (req) begin
                        victim_d = lru_out;
                        retry_d = 1'b1;
                        state_d = (lru_out ? d_out1 : d_out0) ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    l2_write = 1'b1;
                    l2addr_sel = victim_q ? 2'd2 : 2'd1;
                    l2wdata_sel = victim_q;
                    wb_done = l2_resp;
                    state_d = l2_resp ? FILL : WRITEBACK;
                end
                FILL: begin
                    l2_read = 1'b1;
                    load_TD0 = l2_resp & !victim_q;
                    load_v0 = l2_resp & !victim_q;
                    v_in0 = l2_resp & !victim_q;
                    load_d0 = l2_resp & !victim_q;
                    load_TD1 = l2_resp & victim_q;
                    load_v1 = l2_resp & victim_q;
                    v_in1 = l2_resp & victim_q;
                    load_d1 = l2_resp & victim_q;
                    state_d = l2_resp ? IDLE : FILL;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            victim_q <= 1'b0;
            retry_q <= 1'b0;
            hit_q <= '0;
            miss_q <= '0;
            wb_q <= '0;
        end else begin
            state_q <= state_d;
            victim_q <= victim_d;
            retry_q <= retry_d;
            if (mem_resp && !retry_q && !(&hit_q)) hit_q <= hit_q + CNT_WIDTH'(1);
            if (mem_resp && retry_q && !(&miss_q)) miss_q <= miss_q + CNT_WIDTH'(1);
            if (wb_done && !(&wb_q)) wb_q <= wb_q + CNT_WIDTH'(1);
        end
    end
    assign hit_count = reset ? '0 : hit_q;
    assign miss_count = reset ? '0 : miss_q;
    assign wb_count = reset ? '0 : wb_q;
endmodule

// File: doc/l2_cache_control.md
Name: l2_cache_control

Overview:
- FSM that sequences the 2-way, 8-set, 128-bit-line L2 cache datapath.
- Decodes hit/miss from the datapath tag compare and drives way/LRU/dirty/valid load strobes and address/data mux selects.
- Runs the writeback and fill handshakes toward physical memory.
- Keeps saturating hit, miss and writeback counters for performance analysis.

Parameters:
CNT_WIDTH, 16, width of each saturating performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
mem_read  in  1  upstream read request, held until mem_resp
mem_write  in  1  upstream write request, held until mem_resp
mem_resp  out  1  upstream completion pulse, one cycle
hit0, hit1  in  1 each  datapath tag-match-and-valid per way
d_out0, d_out1  in  1 each  dirty bit of indexed set per way
lru_out  in  1  LRU way of indexed set (0 = way0 is victim)
load_lru, lru_in  out  1 each  LRU array write strobe and data
load_TD0, load_d0, load_v0, d_in0, v_in0  out  1 each  way0 tag/data, dirty and valid strobes and data
load_TD1, load_d1, load_v1, d_in1, v_in1  out  1 each  way1 equivalents
l2wdata_sel  out  1  way select for line readout (0 = way0)
l2addr_sel  out  2  0 = CPU line address, 1 = way0 tag address, 2 = way1 tag address
l2_read  out  1  memory read request; also selects fill data in datapath write logic
l2_write  out  1  memory write request
l2_resp  in  1  memory completion
hit_count, miss_count, wb_count  out  CNT_WIDTH each  performance counters

Behaviour:
- Reset is synchronous and active-high; clock is clk.
  - State goes to IDLE and all counters clear to 0.
  - Every output is 0 during reset and in IDLE with no request.
  - Reset asserted mid-writeback or mid-fill drops l2_read/l2_write at that same edge.
  - No partial line write is committed, and no mem_resp is issued.
- Valid bits are cleared by datapath array initialization, not by this block.
- Request decode: a request is mem_read | mem_write. If both are asserted, mem_write wins. Upstream holds address, data and request until mem_resp.
- All outputs are decoded combinationally from state and inputs (Mealy).

IDLE/COMPARE state:
- On a request with hit0|hit1: mem_resp = 1 in the same cycle (zero-wait hit). Set load_lru = 1 and lru_in = 1 if hit0, 0 if hit1. l2wdata_sel selects the hitting way.
- Write hit: additionally set load_TDx = 1, load_dx = 1, d_inx = 1 on the hitting way. l2_read = 0, so the write logic merges mem_wdata per byte-enable.
- hit0 and hit1 together is illegal; way0 takes precedence.
- Miss: latch victim = lru_out into a register.
  - If the victim is dirty (d_out of the victim): go to WRITEBACK.
  - Otherwise: go to FILL.
- Raise a retry flag on miss; it is cleared on mem_resp.

WRITEBACK:
- Drive l2_write = 1, l2addr_sel = 1 + victim, l2wdata_sel = victim.
- Hold all of these until l2_resp, then go to FILL and increment wb_count.

FILL:
- Drive l2_read = 1, l2addr_sel = 0.
- On l2_resp, same cycle:
  - load_TD<victim> = 1.
  - load_v<victim> = 1, v_in = 1.
  - load_d<victim> = 1, d_in = 0.
  - Then go to IDLE.
- The retried access then hits in IDLE.

Other rules:
- l2_read and l2_write are never asserted together and never deassert before l2_resp.
- Counters, all saturating at all-ones with no wrap:
  - hit_count increments on mem_resp when retry is 0.
  - miss_count increments on mem_resp when retry is 1.
  - wb_count increments at writeback completion.
- Latency in cycles: hit 0; clean miss = fill latency + 1; dirty miss = writeback + fill + 1.

Test Plan:
- Reset, then read 0x1234 on an empty cache -> no hit; FILL with l2_read = 1, l2addr_sel = 0; on l2_resp, load_TD0 = load_v0 = 1. Next cycle mem_resp = 1, miss_count = 1, hit_count = 0.
- Repeat read 0x1234 -> mem_resp in the request cycle, load_lru = 1, lru_in = 1, hit_count = 1.
- Write 0x1236 (hit way0) -> load_TD0 = load_d0 = d_in0 = 1, mem_resp in the same cycle. A later eviction of way0 must write back.
- Fill way1 with 0x9234 (same set). Then access 0x5234 with LRU = way0 dirty -> WRITEBACK with l2addr_sel = 1, l2_write held for a 5-cycle l2_resp delay. Then FILL; wb_count = 1; new tag in way0 with d = 0.
- Assert reset during the FILL wait -> l2_read = 0 next cycle, counters = 0, no mem_resp. A fresh read then behaves as a clean miss.
- Preload hit_count to 0xFFFF via 65535 hits (CNT_WIDTH = 16) plus one more hit -> stays 0xFFFF. Separately, mem_read and mem_write together on a hit -> write path taken (load_d set).
